// File: rtl/issue_controller_pkg.sv
// ----------------------------------------------------------------------------
// issue_controller_pkg
// Types and helpers shared by the decode/issue controller:
//   - RV32I major opcode constants
//   - reg_use_t: which register fields an opcode reads and writes
//   - decode_reg_use / is_legal_opcode: opcode lookups
//   - issue FSM state type
// ----------------------------------------------------------------------------
package issue_controller_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
    } reg_use_t;

    typedef enum logic {
        ST_EMPTY,
        ST_HOLD
    } issue_state_t;

    // Unsupported opcodes read and write nothing, so they can never stall.
    function automatic reg_use_t decode_reg_use(input logic [6:0] opcode);
        reg_use_t u;
        u = '0;
        case (opcode)
            OP_REG:                    u = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b1};
            OP_IMM, OP_LOAD, OP_JALR:  u = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1};
            OP_STORE, OP_BRANCH:       u = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0};
            OP_JAL, OP_LUI, OP_AUIPC:  u = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1};
            default:                   u = '0;
        endcase
        return u;
    endfunction

    function automatic logic is_legal_opcode(input logic [6:0] opcode);
        logic legal;
        case (opcode)
            OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/issue_controller_if.sv
// ----------------------------------------------------------------------------
// issue_controller_if
// Bundles the fetch->decode handshake, decode->execute handshake, writeback
// retire port and redirect flush of the issue controller.
//   slave  : the issue controller side
//   master : the surrounding pipeline (fetch / execute / writeback)
// ----------------------------------------------------------------------------
interface issue_controller_if #(
    parameter int XLEN = 32
);
    // fetch -> decode
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    // decode -> execute
    logic            ex_valid;
    logic            ex_ready;
    logic [31:0]     ex_instr;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic            ex_illegal;
    // writeback retire and redirect
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic            flush;

    modport slave (
        input  if_valid, if_instr, if_pc, ex_ready, wb_valid, wb_rd, flush,
        output if_ready, ex_valid, ex_instr, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_illegal
    );

    modport master (
        output if_valid, if_instr, if_pc, ex_ready, wb_valid, wb_rd, flush,
        input  if_ready, ex_valid, ex_instr, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_illegal
    );

endinterface

// File: rtl/issue_controller_reg_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_scoreboard
// One busy bit per architectural register, marking an issued write that has
// not yet retired.
//   clk, rst          : clock, synchronous active-high reset (clears all bits)
//   set_en / set_idx  : mark a register busy at the next edge
//   clr_en / clr_idx  : writeback retire, clears the busy bit
//   rs1/rs2/rd_idx    : combinational lookup indices
//   rs1/rs2/rd_busy   : lookup results
// A set and a clear of the same register in one cycle leaves it busy: the
// newly issued write is the younger one still outstanding. Register 0 is
// never set, so it always reads idle.
// Build option ISSUE_WB_BYPASS_EN: lookups ignore the register being retired
// this cycle so a waiting consumer can issue alongside its writeback.
// ----------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int NREGS = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] rs1_idx,
    input  logic [IDX_W-1:0] rs2_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             rd_busy
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] look_vec;

    // Index 0 is filtered here, which is what keeps busy[0] permanently low.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en && (set_idx != '0)) set_vec[set_idx] = 1'b1;
        if (clr_en && (clr_idx != '0)) clr_vec[clr_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            // Clear first, then OR the set in: set wins on a collision.
            busy <= (busy & ~clr_vec) | set_vec;
        end
    end

`ifdef ISSUE_WB_BYPASS_EN
    assign look_vec = busy & ~clr_vec;
`else
    assign look_vec = busy;
`endif

    assign rs1_busy = look_vec[rs1_idx];
    assign rs2_busy = look_vec[rs2_idx];
    assign rd_busy  = look_vec[rd_idx];

endmodule

// File: rtl/issue_controller.sv
// ----------------------------------------------------------------------------
// issue_controller
// Decode/issue stage of the RV32I core. Buffers one fetched instruction,
// decodes its register usage, stalls on RAW/WAW hazards against a register
// scoreboard and hands the instruction to execute over valid/ready.
//   clk   : core clock
//   rst   : synchronous active-high reset (buffer and scoreboard cleared)
//   bus   : issue_controller_if.slave
//           if_*  fetch offer / accept
//           ex_*  buffered instruction, decoded fields, illegal flag
//           wb_*  writeback retire, clears a busy bit
//           flush redirect, drops the buffer and any fetch offer this cycle
// Build option ISSUE_WB_BYPASS_EN (see reg_scoreboard): a consumer may issue
// in the same cycle as the writeback it waits on.
// ----------------------------------------------------------------------------
module issue_controller
    import issue_controller_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    issue_controller_if.slave   bus
);

    issue_state_t    state;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    reg_use_t        use_q;
    logic            illegal_q;

    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic rs1_busy, rs2_busy, rd_busy;
    logic hazard;
    logic ex_valid;
    logic issue;
    logic if_ready;
    logic accept;

    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];
    assign rd  = instr_q[11:7];

    assign hazard = (use_q.uses_rs1  && rs1_busy) ||
                    (use_q.uses_rs2  && rs2_busy) ||
                    (use_q.writes_rd && rd_busy);

    // Flush masks both handshakes so a redirect never issues the stale
    // instruction nor swallows a wrong-path fetch.
    assign ex_valid = (state == ST_HOLD) && !hazard && !bus.flush;
    assign issue    = ex_valid && bus.ex_ready;
    assign if_ready = ((state == ST_EMPTY) || issue) && !bus.flush;
    assign accept   = bus.if_valid && if_ready;

    reg_scoreboard #(
        .NREGS (NREGS),
        .IDX_W (REG_IDX_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue && use_q.writes_rd),
        .set_idx  (rd),
        .clr_en   (bus.wb_valid),
        .clr_idx  (bus.wb_rd),
        .rs1_idx  (rs1),
        .rs2_idx  (rs2),
        .rd_idx   (rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

    // Buffer FSM. Decode is done on the fetch word at accept time so the
    // buffered flags stay stable alongside the buffered instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            instr_q   <= '0;
            pc_q      <= '0;
            use_q     <= '0;
            illegal_q <= 1'b0;
        end else if (bus.flush) begin
            state <= ST_EMPTY;
        end else if (accept) begin
            state     <= ST_HOLD;
            instr_q   <= bus.if_instr;
            pc_q      <= bus.if_pc;
            use_q     <= decode_reg_use(bus.if_instr[6:0]);
            illegal_q <= !is_legal_opcode(bus.if_instr[6:0]);
        end else if (issue) begin
            state <= ST_EMPTY;
        end
    end

    assign bus.ex_valid   = ex_valid;
    assign bus.if_ready   = if_ready;
    assign bus.ex_instr   = instr_q;
    assign bus.ex_pc      = pc_q;
    assign bus.ex_rs1     = rs1;
    assign bus.ex_rs2     = rs2;
    assign bus.ex_rd      = rd;
    assign bus.ex_illegal = illegal_q;

endmodule

// File: doc/issue_controller.md
Name: issue_controller

Overview:
- Decode/issue stage controller for the RV32I core.
- Holds one fetched instruction in a decode buffer and extracts its register fields.
- Checks a 32-entry register scoreboard for RAW/WAW hazards and issues to execute over a valid/ready handshake.
- Sits between fetch and execute; writeback clears scoreboard entries; execute can flush on a redirect.

Parameters:
- XLEN, 32, data/PC width.
- NREGS, 32, architectural register count; x0 is never busy.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- if_valid  input  1  fetch offers an instruction
- if_ready  output  1  controller accepts the instruction this cycle
- if_instr  input  32  instruction word
- if_pc  input  XLEN  PC of if_instr
- ex_valid  output  1  decoded instruction available to execute
- ex_ready  input  1  execute accepts
- ex_instr  output  32  buffered instruction word
- ex_pc  output  XLEN  buffered PC
- ex_rs1, ex_rs2, ex_rd  output  5 each  register fields (bits 19:15, 24:20, 11:7)
- ex_illegal  output  1  opcode not in the supported RV32I set
- wb_valid  input  1  writeback retires a register write
- wb_rd  input  5  register written back
- flush  input  1  discard the buffered instruction (branch/jump redirect)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: buffer empty; ex_valid=0; if_ready=1 from the first cycle after reset; scoreboard all 0; ex_* data=0.
- Register-use table, keyed by opcode [6:0]:
  - 0110011: uses rs1, rs2, writes rd.
  - 0010011, 0000011, 1100111: use rs1, write rd.
  - 0100011, 1100011: use rs1, rs2; no write.
  - 1101111, 0110111, 0010111: write rd only.
  - Any other opcode: ex_illegal=1; uses no registers; writes nothing.
- States: EMPTY, HOLD (buffer valid).
  - EMPTY→HOLD when if_valid && if_ready.
  - HOLD→EMPTY on issue with no new accept.
  - HOLD→HOLD on issue with a simultaneous accept, or while stalled.
- hazard = (uses_rs1 && busy[rs1]) || (uses_rs2 && busy[rs2]) || (writes_rd && busy[rd]). busy[0] is hard-wired 0.
- ex_valid = HOLD && !hazard && !flush. issue = ex_valid && ex_ready.
- if_ready = (EMPTY || issue) && !flush. This allows one instruction per cycle throughput.
- Latency: an instruction accepted in cycle N may issue in cycle N+1 at the earliest.
- Handshake: once ex_valid is asserted, ex_* fields remain stable until issue or flush.
- Scoreboard:
  - On issue with writes_rd and rd!=0, set busy[rd] at the next edge.
  - wb_valid clears busy[wb_rd].
  - Same rd set and cleared in one cycle: set wins.
  - wb_rd=0 is ignored.
- WAW stall guarantees at most one outstanding write per register.
- flush:
  - Buffer emptied at the next edge; if_ready=0 and ex_valid=0 during the flush cycle; any fetch offer in that cycle is dropped.
  - The scoreboard is untouched, because already-issued instructions still write back.
- Flush wins over a simultaneous issue: no issue occurs, and no busy bit is set.
- Illegal instructions issue normally with ex_illegal=1, so execute can raise the trap.
- rst mid-operation: buffer and scoreboard cleared at that edge; any pending writeback is lost by design, because the whole core resets together.

Optional Feature:
- Macro: ISSUE_WB_BYPASS_EN.
- Defined: hazard lookup uses busy & ~(wb_valid ? onehot(wb_rd) : 0). An instruction waiting on wb_rd may issue in the same cycle as its writeback, saving one stall cycle. The execute stage must forward wb data.
- Undefined: hazard uses registered busy bits only; the dependent instruction issues one cycle after the writeback.

Decomposition:
- Shared types package holds:
  - opcode constants (OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - a reg_use_t struct {uses_rs1, uses_rs2, writes_rd};
  - a decode function opcode→reg_use_t.
- One sub-module, reg_scoreboard: busy vector with set port, clear port and set-wins rule, plus three combinational lookup ports.

Test Plan:
1. Reset → ex_valid=0, if_ready=1, busy=0. Feed `add x3,x1,x2` (0x002081B3) at cycle 1 with ex_ready=1 → ex_valid=1 at cycle 2 with rd=3; busy[3]=1 at cycle 3.
2. RAW: `add x3,x1,x2`, then `addi x4,x3,1` (0x00118213) → second instruction stalls with ex_valid=0 and if_ready=0 until wb_valid with wb_rd=3. It issues the cycle after the writeback, or in the same cycle with ISSUE_WB_BYPASS_EN.
3. WAW: two back-to-back writes to x5 → the second stalls until wb_rd=5 is retired. The x0 destination `addi x0,x0,0` (0x00000013) never stalls and never sets a busy bit.
4. Backpressure: hold ex_ready=0 for 3 cycles with an instruction buffered → ex_valid=1, ex_instr/ex_pc stable, if_ready=0. Release ex_ready → issue, and a new accept occurs in that same cycle.
5. Flush asserted in the same cycle as ex_valid&&ex_ready and if_valid → no issue, busy unchanged, fetch offer dropped, ex_valid=0 the next cycle.
6. Opcode 0x7F → ex_illegal=1, no hazard check, no scoreboard set. Simultaneous issue setting rd=6 and wb_rd=6 → busy[6]=1.
